// File: rtl/store_write_buffer_pkg.sv
// Shared types and helpers for the store write buffer: default depth,
// buffered entry layout and the word-granular address match.
package store_write_buffer_pkg;

   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned DATA_W        = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wbuf_entry_t;

   // Byte offset bits are kept in the entry but never take part in a match.
   function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
      return a[ADDR_W-1:2] == b[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Core-side store/load port plus memory-bus drain port of the write buffer.
interface store_write_buffer_if;
   import store_write_buffer_pkg::*;

   logic              MemWrite;
   logic [ADDR_W-1:0] Mem_WrAddr;
   logic [DATA_W-1:0] Mem_WrData;
   logic [DATA_W-1:0] ReadData;
   logic [DATA_W-1:0] mem_rdata;
   logic              bus_valid;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ready;
   logic              full;
   logic              empty;
   logic              overflow;

   modport master (
      output MemWrite, Mem_WrAddr, Mem_WrData, mem_rdata, bus_ready,
      input  ReadData, bus_valid, bus_addr, bus_wdata, full, empty, overflow
   );

   modport slave (
      input  MemWrite, Mem_WrAddr, Mem_WrData, mem_rdata, bus_ready,
      output ReadData, bus_valid, bus_addr, bus_wdata, full, empty, overflow
   );

endinterface

// File: rtl/wbuf_fifo.sv
// Circular FIFO of buffered stores; exposes every slot, the head pointer and
// the occupancy so the parent can forward and present the head to the bus.
module wbuf_fifo
   import store_write_buffer_pkg::*;
#(
   parameter  int unsigned DEPTH = DEPTH_DEFAULT,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  wbuf_entry_t       wr_entry_i,
   input  logic              rd_ready_i,
   output wbuf_entry_t       entries_o [DEPTH],
   output logic [PTR_W-1:0]  head_o,
   output logic [CNT_W-1:0]  count_o
);

   wbuf_entry_t      mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             deq_c;
   logic             acc_c;

   // A pop in the same cycle frees the slot a full-FIFO push needs.
   always_comb begin
      deq_c   = (count_q != '0) && rd_ready_i;
      acc_c   = wr_en_i && ((count_q < CNT_W'(DEPTH)) || deq_c);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(acc_c) - CNT_W'(deq_c);
      if (deq_c) head_d = head_q + PTR_W'(1);
      if (acc_c) tail_d = tail_q + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; slot validity comes from count.
   always_ff @(posedge clk) begin
      if (rst_n && acc_c) mem_q[tail_q] <= wr_entry_i;
   end

   assign entries_o = mem_q;
   assign head_o    = head_q;
   assign count_o   = count_q;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: queues core stores for the memory bus, forwards the
// youngest matching pending store to loads, and flags dropped stores.
module store_write_buffer
   import store_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   store_write_buffer_if.slave bus_if
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wbuf_entry_t      entries [DEPTH];
   wbuf_entry_t      wr_entry_c;
   wbuf_entry_t      head_entry_c;
   logic [PTR_W-1:0] head;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] idx_c;
   logic [DATA_W-1:0] fwd_data_c;
   logic             full_c;
   logic             drop_c;
   logic             overflow_q, overflow_d;

   assign wr_entry_c.addr = bus_if.Mem_WrAddr;
   assign wr_entry_c.data = bus_if.Mem_WrData;

   wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .wr_en_i    (bus_if.MemWrite),
      .wr_entry_i (wr_entry_c),
      .rd_ready_i (bus_if.bus_ready),
      .entries_o  (entries),
      .head_o     (head),
      .count_o    (count)
   );

   assign full_c       = (count == CNT_W'(DEPTH));
   assign head_entry_c = entries[head];

   assign bus_if.full      = full_c;
   assign bus_if.empty     = (count == '0);
   assign bus_if.bus_valid = (count != '0);
   assign bus_if.bus_addr  = head_entry_c.addr;
   assign bus_if.bus_wdata = head_entry_c.data;

   // Walk oldest to youngest so the last hit is the youngest matching store.
   always_comb begin
      fwd_data_c = bus_if.mem_rdata;
      idx_c      = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx_c = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && word_match(entries[idx_c].addr, bus_if.Mem_WrAddr))
            fwd_data_c = entries[idx_c].data;
      end
   end

   assign bus_if.ReadData = bus_if.MemWrite ? bus_if.mem_rdata : fwd_data_c;

   // Full implies bus_valid, so a full FIFO without bus_ready cannot accept.
   assign drop_c     = bus_if.MemWrite && full_c && !bus_if.bus_ready;
   assign overflow_d = overflow_q | drop_c;

   always_ff @(posedge clk) begin
      if (!reset) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   assign bus_if.overflow = overflow_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a scoreboard of expected bus writes.
module tb_store_write_buffer;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;
   exp_t exp_q[$];
   exp_t mon_e;

   store_write_buffer_if sif();

   store_write_buffer #(.DEPTH(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_if (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input bit push, input bit timed);
      exp_t e;
      sif.MemWrite   = 1'b1;
      sif.Mem_WrAddr = a;
      sif.Mem_WrData = d;
      if (push) begin
         e.addr = a;
         e.data = d;
         e.cyc  = timed ? cyc + 1 : -1;
         exp_q.push_back(e);
      end
      cycle();
      sif.MemWrite = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      exp_q.delete();
   endtask

   // Bus write monitor: every accepted head entry must match the scoreboard.
   always @(negedge clk) begin
      if (reset && sif.bus_valid && sif.bus_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got addr %h data %h expected no write (cycle %0d)",
                     sif.bus_addr, sif.bus_wdata, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("bus_addr", sif.bus_addr, mon_e.addr);
            check("bus_wdata", sif.bus_wdata, mon_e.data);
            if (mon_e.cyc >= 0) check("bus_latency", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset          = 1'b0;
      sif.MemWrite   = 1'b0;
      sif.Mem_WrAddr = '0;
      sif.Mem_WrData = '0;
      sif.mem_rdata  = 32'hDEAD_BEEF;
      sif.bus_ready  = 1'b0;
      cycle();
      cycle();

      // Reset state
      check("rst_bus_valid", 32'(sif.bus_valid), 32'd0);
      check("rst_empty", 32'(sif.empty), 32'd1);
      check("rst_full", 32'(sif.full), 32'd0);
      check("rst_overflow", 32'(sif.overflow), 32'd0);
      check("rst_readdata", sif.ReadData, 32'hDEAD_BEEF);
      reset = 1'b1;
      cycle();

      // Three stores drained back-to-back, each one cycle after its store
      sif.bus_ready = 1'b1;
      store(32'h100, 32'h0000_0011, 1'b1, 1'b1);
      store(32'h104, 32'h0000_0022, 1'b1, 1'b1);
      store(32'h108, 32'h0000_0033, 1'b1, 1'b1);
      cycle();
      check("t1_empty", 32'(sif.empty), 32'd1);
      check("t1_bus_valid", 32'(sif.bus_valid), 32'd0);

      // Stalled bus: fourth store fills, fifth is dropped
      sif.bus_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         store(32'h300 + 32'(4 * i), 32'h5000 + 32'(i), i < 4, 1'b0);
         if (i == 3) begin
            check("t2_full", 32'(sif.full), 32'd1);
            check("t2_no_ovf_yet", 32'(sif.overflow), 32'd0);
         end
      end
      check("t2_overflow", 32'(sif.overflow), 32'd1);
      check("t2_full_after", 32'(sif.full), 32'd1);
      check("t2_bus_addr", sif.bus_addr, 32'h300);
      check("t2_bus_wdata", sif.bus_wdata, 32'h5000);
      cycle();
      check("t2_bus_addr_hold", sif.bus_addr, 32'h300);
      check("t2_overflow_sticky", 32'(sif.overflow), 32'd1);
      do_reset();
      check("t2_rst_overflow", 32'(sif.overflow), 32'd0);
      check("t2_rst_empty", 32'(sif.empty), 32'd1);

      // Full FIFO with a dequeue and a store in the same cycle
      for (int i = 0; i < 4; i++) store(32'h300 + 32'(4 * i), 32'h6000 + 32'(i), 1'b1, 1'b0);
      check("t3_full_before", 32'(sif.full), 32'd1);
      sif.bus_ready = 1'b1;
      store(32'h400, 32'h0000_4444, 1'b1, 1'b0);
      check("t3_full_kept", 32'(sif.full), 32'd1);
      check("t3_overflow", 32'(sif.overflow), 32'd0);
      for (int i = 0; i < 20 && !sif.empty; i++) cycle();
      check("t3_drained", 32'(sif.empty), 32'd1);

      // Forwarding picks the youngest matching word
      sif.bus_ready = 1'b0;
      store(32'h200, 32'h0000_AAAA, 1'b1, 1'b0);
      store(32'h200, 32'h0000_BBBB, 1'b1, 1'b0);
      sif.mem_rdata  = 32'h0000_1234;
      sif.Mem_WrAddr = 32'h202;
      #1;
      check("t4_fwd_youngest", sif.ReadData, 32'h0000_BBBB);
      sif.Mem_WrAddr = 32'h204;
      #1;
      check("t4_no_match", sif.ReadData, 32'h0000_1234);
      sif.Mem_WrAddr = 32'h200;
      sif.bus_ready  = 1'b1;
      #1;
      check("t4_fwd_drain", sif.ReadData, 32'h0000_BBBB);
      cycle();
      check("t4_fwd_inflight", sif.ReadData, 32'h0000_BBBB);
      cycle();
      check("t4_after_drain", sif.ReadData, 32'h0000_1234);
      check("t4_empty", 32'(sif.empty), 32'd1);

      // Reset with three pending entries discards them
      sif.bus_ready = 1'b0;
      store(32'h500, 32'h0000_0500, 1'b1, 1'b0);
      store(32'h504, 32'h0000_0504, 1'b1, 1'b0);
      store(32'h508, 32'h0000_0508, 1'b1, 1'b0);
      sif.MemWrite   = 1'b1;
      sif.Mem_WrAddr = 32'h600;
      sif.Mem_WrData = 32'h0000_0600;
      do_reset();
      sif.MemWrite = 1'b0;
      check("t5_bus_valid", 32'(sif.bus_valid), 32'd0);
      check("t5_empty", 32'(sif.empty), 32'd1);
      check("t5_overflow", 32'(sif.overflow), 32'd0);
      sif.bus_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t5_stay_idle", 32'(sif.bus_valid), 32'd0);
      end

      check("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 MemWrite  input  1  core store strobe; one word store per asserted cycle.
REQ-005 Mem_WrAddr  input  32  core store address, and load address when MemWrite=0.
REQ-006 Mem_WrData  input  32  core store data.
REQ-007 ReadData  output  32  load data returned to the core, after forwarding.
REQ-008 mem_rdata  input  32  combinational read data from data memory at Mem_WrAddr.
REQ-009 bus_valid  output  1  head entry presented to the memory bus.
REQ-010 bus_addr  output  32  head entry address.
REQ-011 bus_wdata  output  32  head entry data.
REQ-012 bus_ready  input  1  memory accepts the head entry this cycle.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 overflow  output  1  sticky flag for a dropped store.

Function
REQ-016 The block SHALL hold a circular FIFO of DEPTH {addr,data} entries with head/tail pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-017 The dequeue condition SHALL be bus_valid && bus_ready, and the head pointer SHALL advance by one on dequeue.
REQ-018 The accept condition SHALL be MemWrite && (count < DEPTH || dequeue); on accept, {Mem_WrAddr, Mem_WrData} is written at the tail and the tail advances.
REQ-019 Count SHALL update as count + accept - dequeue; a simultaneous accept and dequeue leaves count unchanged, whether the FIFO is full or at any other level.
REQ-020 When MemWrite is asserted while the FIFO is full and there is no dequeue, the store SHALL be dropped, FIFO state SHALL be unchanged, and overflow SHALL be set to 1 on the next edge.
REQ-021 Once set, overflow SHALL stay 1 until reset.
REQ-022 bus_valid SHALL equal !empty, and bus_addr/bus_wdata SHALL be driven from the head entry; the bus outputs SHALL be held stable while bus_valid && !bus_ready.
REQ-023 A store accepted at edge N SHALL be visible on the bus at the earliest in the cycle after edge N; there is no combinational path from input to bus.
REQ-024 Forwarding: when MemWrite=0, ReadData SHALL be the data of the youngest valid entry whose addr[31:2] equals Mem_WrAddr[31:2], otherwise mem_rdata.
REQ-025 An entry that is being dequeued in the current cycle SHALL still be eligible for forwarding.
REQ-026 Stores SHALL be word-granular only; address bits [1:0] are stored but ignored when matching.
REQ-027 full and empty SHALL be combinational decodes of count.

Reset
REQ-028 While reset=0 at an edge, the block SHALL set count=0, head=0, tail=0 and overflow=0; stores presented in that cycle SHALL be discarded.
REQ-029 After reset the outputs SHALL be: bus_valid=0, empty=1, full=0, overflow=0, and ReadData=mem_rdata.
REQ-030 Reset asserted mid-drain SHALL discard all pending entries without completing the in-flight bus write.
REQ-031 Entry storage SHALL NOT require reset; it is qualified by count.

Structure
REQ-032 A shared package SHALL hold the DEPTH default, the entry struct {addr[31:0], data[31:0]}, and the word-match helper.
REQ-033 The FIFO storage and pointers SHALL be one sub-module, wbuf_fifo; the forwarding comparator and overflow logic SHALL live in the top level.

Verification
REQ-034 Three stores to 0x100, 0x104 and 0x108 with bus_ready=1 -> bus writes in order, each one cycle after its store, then empty=1.
REQ-035 bus_ready=0 with 5 stores at DEPTH=4 -> full=1 after the 4th store, the 5th is dropped, overflow=1, and the bus shows the 1st entry unchanged.
REQ-036 FIFO full while bus_ready=1 and MemWrite=1 on the same cycle -> store accepted, count stays 4, overflow stays 0.
REQ-037 Stores 0x200<-0xAAAA then 0x200<-0xBBBB with the bus stalled, then a load from 0x202 -> ReadData=0xBBBB, not mem_rdata.
REQ-038 reset=0 for one cycle with 3 pending entries -> the next cycle shows bus_valid=0, empty=1, overflow=0, and no further bus writes occur.
